mult_arbiter: RTL

- Shares one MBE/Dadda multiplier instance among N_REQ independent requesters.
- Each requester sends operands over a valid/ready request channel and gets its product back over a per-requester valid/ready response channel.
- Selects requesters round-robin and drives the multiplier operands from registers.
- Waits the multiplier's fixed pipeline latency, then returns the product to the granted requester and accepts the next request.

---
 rtl/mult_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
//------------------------------------------------------------------------------
// mult_arbiter
//
// Shares one external multiplier among N_REQ requesters. A request (operand
// pair) is taken from one requester at a time. The operands are held in
// registers that drive the multiplier. After the multiplier's fixed pipeline
// latency the product is captured. It is then returned on the granted
// requester's response channel.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. The sender keeps its data stable while
// valid is high and ready is low. A requester may drop req_valid before it is
// accepted.
//
// Arbitration: round-robin starting at rr_ptr. When MULT_ARB_FIXED_PRIO_EN
// is defined, the lowest index wins and rr_ptr stays at 0.
//
// Parameters:
//   N_REQ  number of requesters (2..8)
//   NB     operand width, product is 2*NB
//   LAT    multiplier register stages between mul_a/mul_b and mul_p
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready request channel, one bit per requester
//   req_a, req_b        packed operands, requester i at [i*NB +: NB]
//   rsp_valid/rsp_ready response channel, one bit per requester
//   rsp_data            product, shared by all requesters
//   mul_a, mul_b        registered operands to the multiplier
//   mul_p               product from the multiplier
//   grant_id            current or last granted requester
//   busy                high whenever the FSM is not IDLE
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module mult_arbiter #(
    parameter int N_REQ = 4,
    parameter int NB    = 32,
    parameter int LAT   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*NB-1:0]      req_a,
    input  logic [N_REQ*NB-1:0]      req_b,
    output logic [N_REQ-1:0]         rsp_valid,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic [2*NB-1:0]          rsp_data,
    output logic [NB-1:0]            mul_a,
    output logic [NB-1:0]            mul_b,
    input  logic [2*NB-1:0]          mul_p,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
);

    localparam int GW = $clog2(N_REQ);
    // The counter needs at least one bit, even when LAT is 0.
    localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t        state;
    logic [GW-1:0] rr_ptr;
    logic [CW-1:0] cnt;

    logic [GW-1:0] gnt;
    logic          gnt_found;

    // Take the first valid requester, starting at rr_ptr and wrapping.
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                gnt_found = 1'b1;
                gnt       = GW'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    // Ready is offered only in IDLE and only to the winner. It is gated by
    // rst_n so that it stays low while reset is asserted.
    assign req_ready = (rst_n && (state == IDLE) && gnt_found)
                       ? (N_REQ'(1) << gnt) : '0;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            grant_id  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // gnt_found means req_ready[gnt] and req_valid[gnt] are
                    // both high, so a transfer happens on this edge.
                    if (gnt_found) begin
                        mul_a    <= req_a[gnt*NB +: NB];
                        mul_b    <= req_b[gnt*NB +: NB];
                        grant_id <= gnt;
`ifdef MULT_ARB_FIXED_PRIO_EN
                        rr_ptr   <= '0;
`else
                        rr_ptr   <= GW'((int'(gnt) + 1) % N_REQ);
`endif
                        cnt      <= CW'(LAT);
                        state    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    // The first COMPUTE edge is one after mul_a/mul_b load.
                    // Counting LAT down to 0 gives LAT+1 edges, so mul_p has
                    // settled by the time it is captured.
                    if (cnt == '0) begin
                        rsp_data            <= mul_p;
                        rsp_valid[grant_id] <= 1'b1;
                        state               <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_id]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
